cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 5: number of requesters (res1..res4 ALU stations, res_br).
REQ-002 Parameter NUM_PORTS, default 2: number of CDB broadcast slots per cycle.
REQ-003 Parameter TAG_W, default 3: ROB tag width; there are 2**TAG_W ROB entries.
REQ-004 Parameter DATA_W, default 32: result data width.
REQ-005 clk  input  1: the only clock; all state updates on its rising edge.
REQ-006 rst  input  1: reset, synchronous and active-high.
REQ-007 req_valid  input  NUM_REQ: requester i presents a finished result.
REQ-008 req_tag  input  NUM_REQ x TAG_W: destination ROB tag per requester.
REQ-009 req_data  input  NUM_REQ x DATA_W: result data per requester.
REQ-010 req_ready  output  NUM_REQ: grant; the result is accepted in this cycle.
REQ-011 flush  input  1: branch-mispredict flush; drops everything in flight.
REQ-012 cdb_valid  output  NUM_PORTS: broadcast slot p is valid.
REQ-013 cdb_tag  output  NUM_PORTS x TAG_W: tag broadcast on slot p.
REQ-014 cdb_data  output  NUM_PORTS x DATA_W: data broadcast on slot p.
REQ-015 rob_set_valid  output  2**TAG_W: one-hot OR of the tags on valid slots; drives the ROB valid bits.

Function
REQ-016 req_ready SHALL be combinational from req_valid, rr_ptr and flush.
REQ-017 Each cycle the block SHALL grant at most NUM_PORTS valid requesters, scanning circularly from index rr_ptr upward.
REQ-018 Slots SHALL be filled in scan order: the first grantee goes to slot 0, the next to slot 1.
REQ-019 Granted tag and data SHALL be registered, so cdb_* shows them exactly 1 cycle after the grant; unfilled slots show cdb_valid=0.
REQ-020 After any grant, rr_ptr SHALL advance to (last granted index + 1) mod NUM_REQ; with no grant it SHALL hold.
REQ-021 A requester SHALL hold req_valid, req_tag and req_data stable until it sees req_ready; the arbiter does not buffer ungranted requests.
REQ-022 When flush=1, req_ready SHALL be all zeros and every cdb_valid bit SHALL be 0 on the next cycle; rr_ptr SHALL hold.
REQ-023 When fewer than NUM_PORTS requesters are valid, all of them SHALL be granted in the same cycle.
REQ-024 Wrap-around: the scan SHALL pass from index NUM_REQ-1 to index 0.
REQ-025 A valid requester SHALL be granted within ceil(NUM_REQ/NUM_PORTS) cycles of raising req_valid, absent flush.
REQ-026 Two valid slots carrying the same tag is a protocol error, flagged by a simulation-only assertion.

Reset
REQ-027 While rst=1: rr_ptr=0, cdb_valid=0, cdb_tag=0, cdb_data=0, rob_set_valid=0, req_ready=0.
REQ-028 rst SHALL take priority over flush and over any in-flight grant; results granted in the reset cycle are lost.

Configuration
REQ-029 With macro CDB_ARB_STALL_CNT_EN defined, the block SHALL add output stall_cnt (NUM_REQ x 16).
REQ-030 Each stall_cnt counter SHALL increment once per cycle in which req_valid=1 and req_ready=0, saturate at 16'hFFFF, and clear on rst.
REQ-031 Without CDB_ARB_STALL_CNT_EN, the port and the counters SHALL be absent; arbitration behaviour is identical.

Structure
REQ-032 The typedef cdb_slot_t (valid, tag, data) and the constants NUM_CDB_PORTS and ROB_TAG_W SHALL live in package tomasula_types.
REQ-033 A sub-module rr_pick SHALL be used: a combinational circular priority picker returning the first valid index at or after a given start index.
REQ-034 The top level SHALL chain NUM_PORTS instances of rr_pick, masking earlier winners.

Verification
REQ-035 rst held 2 cycles, then all req_valid=1 -> no cdb_valid during reset; grants go to 0,1, then 2,3, then 4,0; rr_ptr values are 2, 4, 1.
REQ-036 Only req 3 valid (tag 5, data 32'hDEADBEEF) -> req_ready[3]=1; next cycle cdb_valid=2'b01, slot 0 = tag 5 / 32'hDEADBEEF; rob_set_valid=8'h20.
REQ-037 rr_ptr=4, req 4 and req 1 valid -> slot0=req4, slot1=req1 (wrap-around); rr_ptr becomes 2.
REQ-038 flush=1 with 3 valid requesters -> req_ready=0; next cycle cdb_valid=0; rr_ptr unchanged.
REQ-039 With CDB_ARB_STALL_CNT_EN: req 4 stalled 3 cycles by requests 0-3 -> stall_cnt[4]=3; a forced saturation test holds at 16'hFFFF.
REQ-040 Random valid traffic, 10k cycles -> no requester waits more than 3 cycles; each tag is broadcast exactly once per grant.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared Tomasulo types for the CDB arbiter: broadcast slot record and default sizes.
package tomasula_types;

    localparam int NUM_CDB_REQ   = 5;
    localparam int NUM_CDB_PORTS = 2;
    localparam int ROB_TAG_W     = 3;
    localparam int CDB_DATA_W    = 32;
    localparam int STALL_CNT_W   = 16;

    typedef struct packed {
        logic                  valid;
        logic [ROB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] data;
    } cdb_slot_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Requester/CDB bundle of the arbiter. stall_cnt exists only with CDB_ARB_STALL_CNT_EN defined.
interface cdb_arbiter_if
    import tomasula_types::*;
#(
    parameter int NUM_REQ   = NUM_CDB_REQ,
    parameter int NUM_PORTS = NUM_CDB_PORTS,
    parameter int TAG_W     = ROB_TAG_W,
    parameter int DATA_W    = CDB_DATA_W
) ();

    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ-1:0][TAG_W-1:0]     req_tag;
    logic [NUM_REQ-1:0][DATA_W-1:0]    req_data;
    logic [NUM_REQ-1:0]                req_ready;
    logic                              flush;
    logic [NUM_PORTS-1:0]              cdb_valid;
    logic [NUM_PORTS-1:0][TAG_W-1:0]   cdb_tag;
    logic [NUM_PORTS-1:0][DATA_W-1:0]  cdb_data;
    logic [2**TAG_W-1:0]               rob_set_valid;
`ifdef CDB_ARB_STALL_CNT_EN
    logic [NUM_REQ-1:0][STALL_CNT_W-1:0] stall_cnt;
`endif

    modport master (
        output req_valid, req_tag, req_data, flush,
        input  req_ready, cdb_valid, cdb_tag, cdb_data, rob_set_valid
`ifdef CDB_ARB_STALL_CNT_EN
        , input stall_cnt
`endif
    );

    modport slave (
        input  req_valid, req_tag, req_data, flush,
        output req_ready, cdb_valid, cdb_tag, cdb_data, rob_set_valid
`ifdef CDB_ARB_STALL_CNT_EN
        , output stall_cnt
`endif
    );

endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational circular priority picker: first set bit of valid at or after index start.
module rr_pick #(
    parameter int N     = 5,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        int j;
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(start) + k;
            if (j >= N) j = j - N;
            if (!found && valid[j]) begin
                found = 1'b1;
                idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: round-robin grant of up to NUM_PORTS finished results per cycle onto registered
// broadcast slots. Optional per-requester stall counters with CDB_ARB_STALL_CNT_EN defined.
module cdb_arbiter
    import tomasula_types::*;
#(
    parameter int NUM_REQ   = NUM_CDB_REQ,
    parameter int NUM_PORTS = NUM_CDB_PORTS,
    parameter int TAG_W     = ROB_TAG_W,
    parameter int DATA_W    = CDB_DATA_W
) (
    input logic          clk,
    input logic          rst,
    cdb_arbiter_if.slave bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] cand;
    logic [NUM_PORTS-1:0] found;
    logic [IDX_W-1:0]   pick_idx [NUM_PORTS];
    logic               any_grant;
    logic [IDX_W-1:0]   last_idx;
    logic [IDX_W-1:0]   next_ptr;
    logic               dup_tag;

    // Reset and flush both suppress every grant in the current cycle.
    assign cand = (rst || bus.flush) ? '0 : bus.req_valid;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_pick
        logic [NUM_REQ-1:0] avail;
        logic [NUM_REQ-1:0] remain;

        if (p == 0) begin : g_first
            assign avail = cand;
        end else begin : g_next
            assign avail = g_pick[p-1].remain;
        end

        rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
            .valid (avail),
            .start (rr_ptr),
            .found (found[p]),
            .idx   (pick_idx[p])
        );

        assign remain = found[p] ? (avail & ~(NUM_REQ'(1) << pick_idx[p])) : avail;
    end

    assign bus.req_ready = cand & ~g_pick[NUM_PORTS-1].remain;

    always_comb begin
        any_grant = found[0];
        last_idx  = rr_ptr;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (found[p]) last_idx = pick_idx[p];
        end
        next_ptr = (last_idx == IDX_W'(NUM_REQ - 1)) ? '0 : last_idx + IDX_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr        <= '0;
            bus.cdb_valid <= '0;
            bus.cdb_tag   <= '0;
            bus.cdb_data  <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                bus.cdb_valid[p] <= found[p];
                bus.cdb_tag[p]   <= found[p] ? bus.req_tag[pick_idx[p]]  : '0;
                bus.cdb_data[p]  <= found[p] ? bus.req_data[pick_idx[p]] : '0;
            end
            if (any_grant) rr_ptr <= next_ptr;
        end
    end

    always_comb begin
        bus.rob_set_valid = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (bus.cdb_valid[p]) bus.rob_set_valid[bus.cdb_tag[p]] = 1'b1;
        end
    end

    // Two live slots naming the same ROB entry means a requester protocol violation upstream.
    always_comb begin
        dup_tag = 1'b0;
        for (int a = 0; a < NUM_PORTS; a++) begin
            for (int b = a + 1; b < NUM_PORTS; b++) begin
                if (bus.cdb_valid[a] && bus.cdb_valid[b] && bus.cdb_tag[a] == bus.cdb_tag[b])
                    dup_tag = 1'b1;
            end
        end
    end

    a_no_dup_tag: assert property (@(posedge clk) disable iff (rst) !dup_tag);

`ifdef CDB_ARB_STALL_CNT_EN
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst) begin
                bus.stall_cnt[i] <= '0;
            end else if (bus.req_valid[i] && !bus.req_ready[i] && bus.stall_cnt[i] != '1) begin
                bus.stall_cnt[i] <= bus.stall_cnt[i] + STALL_CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed scenarios plus random traffic against a queue-level model.
module tb_cdb_arbiter;
    import tomasula_types::*;

    localparam int NUM_REQ  = NUM_CDB_REQ;
    localparam int P        = NUM_CDB_PORTS;
    localparam int TAG_W    = ROB_TAG_W;
    localparam int DATA_W   = CDB_DATA_W;
    localparam int MAX_WAIT = (NUM_REQ + P - 1) / P;

    typedef cdb_slot_t [P-1:0] slots_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.NUM_REQ(NUM_REQ), .NUM_PORTS(P), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

    cdb_arbiter #(.NUM_REQ(NUM_REQ), .NUM_PORTS(P), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    bit                pend [NUM_REQ];
    logic [TAG_W-1:0]  tag  [NUM_REQ];
    logic [DATA_W-1:0] data [NUM_REQ];
    int                age  [NUM_REQ];
    int                m_ptr = 0;
    slots_t            exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic raise(input int i, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        pend[i] = 1'b1;
        tag[i]  = t;
        data[i] = d;
        age[i]  = 1;
    endtask

    function automatic logic [TAG_W-1:0] free_tag();
        int  free_list [$];
        bit  used;
        for (int t = 0; t < 2**TAG_W; t++) begin
            used = 1'b0;
            for (int i = 0; i < NUM_REQ; i++)
                if (pend[i] && tag[i] == TAG_W'(t)) used = 1'b1;
            if (!used) free_list.push_back(t);
        end
        return TAG_W'(free_list[$urandom_range(0, free_list.size() - 1)]);
    endfunction

    // Reference: walk requesters circularly from the pointer, take the first P pending ones.
    task automatic model(input bit kill, input bit r, output logic [NUM_REQ-1:0] rdy, output slots_t s);
        int n = 0;
        int last = -1;
        rdy = '0;
        s   = '0;
        if (!kill) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int j = (m_ptr + k) % NUM_REQ;
                if (pend[j] && n < P) begin
                    rdy[j] = 1'b1;
                    s[n]   = '{valid: 1'b1, tag: tag[j], data: data[j]};
                    n++;
                    last = j;
                end
            end
        end
        if (r) m_ptr = 0;
        else if (last >= 0) m_ptr = (last + 1) % NUM_REQ;
    endtask

    task automatic step(input bit r, input bit f);
        logic [NUM_REQ-1:0] rdy;
        slots_t s;
        @(posedge clk);
        #2;
        check("rr_ptr", 64'(dut.rr_ptr), 64'(m_ptr));
        rst       = r;
        bus.flush = f;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_valid[i] = pend[i];
            bus.req_tag[i]   = tag[i];
            bus.req_data[i]  = data[i];
        end
        #1;
        model(r || f, r, rdy, s);
        check("req_ready", 64'(bus.req_ready), 64'(rdy));
        exp_q.push_back(s);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pend[i]) begin
                if (bus.req_ready[i]) begin
                    n_checks++;
                    if (age[i] > MAX_WAIT) begin
                        n_errors++;
                        $display("FAIL wait req%0d: waited %0d cycles, limit %0d", i, age[i], MAX_WAIT);
                    end
                    pend[i] = 1'b0;
                end else if (!(r || f)) begin
                    age[i]++;
                end
            end
        end
    endtask

    // Monitor: one cycle after each issued cycle, compare broadcast slots with the queued expectation.
    initial begin
        slots_t e;
        logic [2**TAG_W-1:0] rob;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                rob = '0;
                for (int p = 0; p < P; p++) begin
                    check($sformatf("cdb_valid[%0d]", p), 64'(bus.cdb_valid[p]), 64'(e[p].valid));
                    if (e[p].valid) begin
                        check($sformatf("cdb_tag[%0d]", p), 64'(bus.cdb_tag[p]), 64'(e[p].tag));
                        check($sformatf("cdb_data[%0d]", p), 64'(bus.cdb_data[p]), 64'(e[p].data));
                        rob[e[p].tag] = 1'b1;
                    end
                end
                check("rob_set_valid", 64'(bus.rob_set_valid), 64'(rob));
            end
        end
    end

    initial begin
        bus.flush     = 1'b0;
        bus.req_valid = '0;
        bus.req_tag   = '0;
        bus.req_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pend[i] = 1'b0;
            tag[i]  = '0;
            data[i] = '0;
            age[i]  = 0;
        end

        // Reset two cycles with everyone requesting, then round-robin pairs 0,1 / 2,3 / 4,0.
        for (int i = 0; i < NUM_REQ; i++) raise(i, TAG_W'(i), $urandom());
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("grant pair 0,1", 64'(bus.req_ready), 64'h03);
        raise(0, TAG_W'(0), $urandom());
        raise(1, TAG_W'(1), $urandom());
        step(1'b0, 1'b0);
        check("grant pair 2,3", 64'(bus.req_ready), 64'h0C);
        check("rr_ptr after 0,1", 64'(dut.rr_ptr), 64'd2);
        step(1'b0, 1'b0);
        check("grant pair 4,0", 64'(bus.req_ready), 64'h11);
        check("rr_ptr after 2,3", 64'(dut.rr_ptr), 64'd4);
        step(1'b0, 1'b0);
        check("rr_ptr after 4,0", 64'(dut.rr_ptr), 64'd1);

        // Single requester 3 with tag 5.
        raise(3, TAG_W'(5), 32'hDEADBEEF);
        step(1'b0, 1'b0);
        check("single grant req3", 64'(bus.req_ready), 64'h08);

        // Wrap-around from pointer 4: slot 0 = req 4, slot 1 = req 1.
        raise(4, TAG_W'(2), 32'h4444_0004);
        raise(1, TAG_W'(6), 32'h1111_0001);
        step(1'b0, 1'b0);
        check("wrap grant 4,1", 64'(bus.req_ready), 64'h12);
        check("single cdb_valid", 64'(bus.cdb_valid), 64'h1);
        check("single cdb_tag0", 64'(bus.cdb_tag[0]), 64'd5);
        check("single cdb_data0", 64'(bus.cdb_data[0]), 64'hDEADBEEF);
        check("single rob_set_valid", 64'(bus.rob_set_valid), 64'h20);
        step(1'b0, 1'b0);
        check("wrap cdb_valid", 64'(bus.cdb_valid), 64'h3);
        check("wrap slot0 tag", 64'(bus.cdb_tag[0]), 64'd2);
        check("wrap slot1 tag", 64'(bus.cdb_tag[1]), 64'd6);
        check("wrap rob_set_valid", 64'(bus.rob_set_valid), 64'h44);
        check("rr_ptr after wrap", 64'(dut.rr_ptr), 64'd2);

        // Flush with three requesters: nothing granted, pointer held.
        raise(0, TAG_W'(1), $urandom());
        raise(2, TAG_W'(3), $urandom());
        raise(3, TAG_W'(4), $urandom());
        step(1'b0, 1'b1);
        check("flush req_ready", 64'(bus.req_ready), 64'h0);
        step(1'b0, 1'b0);
        check("flush cdb_valid", 64'(bus.cdb_valid), 64'h0);
        check("rr_ptr after flush", 64'(dut.rr_ptr), 64'd2);
        step(1'b0, 1'b0);

`ifdef CDB_ARB_STALL_CNT_EN
        // Requester 4 stalled by a flush and two rounds of requests 0-3.
        step(1'b1, 1'b0);
        for (int i = 0; i < NUM_REQ; i++) raise(i, TAG_W'(i), $urandom());
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("stall_cnt[4]", 64'(bus.stall_cnt[4]), 64'd3);
        raise(0, TAG_W'(0), $urandom());
        for (int c = 0; c < 65540; c++) step(1'b0, 1'b1);
        check("stall_cnt[0] saturated", 64'(bus.stall_cnt[0]), 64'hFFFF);
        step(1'b0, 1'b0);
`endif

        // Random traffic with occasional flushes; requesters hold until granted.
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 55) raise(i, free_tag(), $urandom());
            end
            step(1'b0, $urandom_range(0, 99) < 3);
        end

        for (int c = 0; c < 2 * MAX_WAIT + 2; c++) step(1'b0, 1'b0);
        @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
